serial_cmd_encoder: RTL



---
 rtl/serial_cmd_defs_pkg.sv | 23 ++
 rtl/serial_cmd_checksum.sv | 20 ++
 rtl/serial_cmd_encoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_cmd_defs_pkg.sv
// Shared definitions for the serial command path (encoder and decoder):
// framing bytes, payload limits and FSM state encodings.
package serial_cmd_defs_pkg;

   localparam logic [7:0]  SOF_BYTE          = 8'hFF;
   localparam logic [7:0]  EOF_BYTE          = 8'hEE;
   localparam int unsigned MAX_PAYLOAD_BYTES = 8;
   localparam int unsigned FRAME_OVERHEAD    = 5;

   typedef logic [MAX_PAYLOAD_BYTES-1:0][7:0] payload_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Total bytes on the wire for a frame carrying len payload bytes.
   function automatic logic [7:0] frame_len(input logic [3:0] len);
      return 8'(len) + 8'(FRAME_OVERHEAD);
   endfunction

endpackage

// File: rtl/serial_cmd_checksum.sv
// Frame checksum: XOR of code, zero-extended len and the first len payload bytes.
module serial_cmd_checksum
   import serial_cmd_defs_pkg::*;
(
   input  logic [7:0] code_i,
   input  logic [3:0] len_i,
   input  payload_t   payload_i,
   output logic [7:0] chk_o
);

   always_comb begin
      chk_o = code_i ^ {4'h0, len_i};
      for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
         if (4'(i) < len_i) begin
            chk_o = chk_o ^ payload_i[i];
         end
      end
   end

endmodule

// File: rtl/serial_cmd_encoder.sv
// Response framer: latches one response, pushes SOF/CODE/LEN/payload/CHK/EOF into
// the TX FIFO under backpressure, then holds rsp_sent until acknowledged.
module serial_cmd_encoder
   import serial_cmd_defs_pkg::*;
#(
   parameter logic [7:0]  SOF         = SOF_BYTE,
   parameter logic [7:0]  EOF         = EOF_BYTE,
   parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_BYTES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rsp_ready,
   input  logic [7:0] rsp_code,
   input  logic [3:0] rsp_len,
   input  logic [7:0] rsp_payload_r0,
   input  logic [7:0] rsp_payload_r1,
   input  logic [7:0] rsp_payload_r2,
   input  logic [7:0] rsp_payload_r3,
   input  logic [7:0] rsp_payload_r4,
   input  logic [7:0] rsp_payload_r5,
   input  logic [7:0] rsp_payload_r6,
   input  logic [7:0] rsp_payload_r7,
   input  logic       fifo_full,
   output logic       fifo_push,
   output logic [7:0] fifo_data,
   output logic       rsp_busy,
   output logic       rsp_sent,
   input  logic       rsp_sent_received,
   output logic [7:0] rsp_bytes_sent,
   output logic       rsp_encode_success,
   output state_e     dbg_state
);

   state_e     state_q;
   logic [3:0] idx_q;
   logic [7:0] code_q;
   logic [3:0] len_q;
   payload_t   payload_q;
   logic [7:0] bytes_sent_q;
   logic       success_q;
   logic       sent_q;
   logic       busy_q;

   logic [7:0] chk_d;
   logic [7:0] frame_byte_d;
   logic [2:0] pay_idx_d;
   logic       last_byte_d;
   logic       push_d;

   serial_cmd_checksum u_checksum (
      .code_i    (code_q),
      .len_i     (len_q),
      .payload_i (payload_q),
      .chk_o     (chk_d)
   );

   // Byte positions 3..len+2 are payload; CHK and EOF follow at len+3 and len+4.
   always_comb begin
      pay_idx_d    = 3'(idx_q - 4'd3);
      last_byte_d  = (idx_q == len_q + 4'd4);
      frame_byte_d = 8'h00;
      if (idx_q == 4'd0) begin
         frame_byte_d = SOF;
      end else if (idx_q == 4'd1) begin
         frame_byte_d = code_q;
      end else if (idx_q == 4'd2) begin
         frame_byte_d = {4'h0, len_q};
      end else if (idx_q == len_q + 4'd3) begin
         frame_byte_d = chk_d;
      end else if (last_byte_d) begin
         frame_byte_d = EOF;
      end else begin
         frame_byte_d = payload_q[pay_idx_d];
      end
   end

   assign push_d    = (state_q == ST_SEND) && !fifo_full;
   assign fifo_push = push_d;
   assign fifo_data = (state_q == ST_SEND) ? frame_byte_d : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= 4'd0;
         code_q       <= 8'h00;
         len_q        <= 4'd0;
         payload_q    <= '0;
         bytes_sent_q <= 8'h00;
         success_q    <= 1'b0;
         sent_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rsp_ready) begin
                  code_q    <= rsp_code;
                  len_q     <= rsp_len;
                  payload_q <= {rsp_payload_r7, rsp_payload_r6, rsp_payload_r5, rsp_payload_r4,
                                rsp_payload_r3, rsp_payload_r2, rsp_payload_r1, rsp_payload_r0};
                  idx_q     <= 4'd0;
                  busy_q    <= 1'b1;
                  if (rsp_len > 4'(MAX_PAYLOAD)) begin
                     state_q      <= ST_DONE;
                     success_q    <= 1'b0;
                     bytes_sent_q <= 8'h00;
                     sent_q       <= 1'b1;
                  end else begin
                     state_q <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               if (push_d) begin
                  if (last_byte_d) begin
                     state_q      <= ST_DONE;
                     success_q    <= 1'b1;
                     bytes_sent_q <= frame_len(len_q);
                     sent_q       <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            ST_DONE: begin
               // Acknowledge wins over a coincident request; the request is retaken from IDLE.
               if (rsp_sent_received) begin
                  state_q <= ST_IDLE;
                  idx_q   <= 4'd0;
                  sent_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               idx_q   <= 4'd0;
               sent_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_busy           = busy_q;
   assign rsp_sent           = sent_q;
   assign rsp_bytes_sent     = bytes_sent_q;
   assign rsp_encode_success = success_q;
   assign dbg_state          = state_q;

endmodule
